// File: rtl/gyro_bias_calibrator.sv
// gyro_bias_calibrator: sequences zero-rate bias calibration of a 3-axis gyro
// stream (settle, average 2^LOG_SAMPLES samples, latch) and applies the
// resulting per-axis bias to every sample with saturation.
module gyro_bias_calibrator #(
    parameter int WIDTH          = 16,
    parameter int LOG_SAMPLES    = 10,
    parameter int SETTLE_SAMPLES = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    cal_start_in,
    input  logic                    sample_valid_in,
    input  logic signed [WIDTH-1:0] gx_in,
    input  logic signed [WIDTH-1:0] gy_in,
    input  logic signed [WIDTH-1:0] gz_in,
    output logic signed [WIDTH-1:0] gx_out,
    output logic signed [WIDTH-1:0] gy_out,
    output logic signed [WIDTH-1:0] gz_out,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] bias_x_out,
    output logic signed [WIDTH-1:0] bias_y_out,
    output logic signed [WIDTH-1:0] bias_z_out,
    output logic                    busy_out,
    output logic                    calibrated_out,
    output logic                    done_out
);

    // Accumulators are wide enough to hold 2^LOG_SAMPLES full-scale samples.
    localparam int ACC_W    = WIDTH + LOG_SAMPLES;
    localparam int SETTLE_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam int CNT_W    = (LOG_SAMPLES > SETTLE_W) ? LOG_SAMPLES : SETTLE_W;

    // Counter values seen while the final settle / accumulate sample arrives.
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
    localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'((1 << LOG_SAMPLES) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_LATCH,
        ST_CAL
    } state_t;

    // A zero-length settle window skips straight to averaging.
    localparam state_t START_STATE = (SETTLE_SAMPLES == 0) ? ST_ACCUM : ST_SETTLE;

    state_t                   state;
    state_t                   next_state;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc_x;
    logic signed [ACC_W-1:0]  acc_y;
    logic signed [ACC_W-1:0]  acc_z;
    logic                     settle_last;
    logic                     accum_last;
    logic                     busy_d;
    logic                     cal_d;
    logic                     done_d;

    assign settle_last = (cnt == SETTLE_LAST);
    assign accum_last  = (cnt == ACCUM_LAST);

    // Subtract at WIDTH+1 bits and clamp to the signed WIDTH-bit range.
    function automatic logic signed [WIDTH-1:0] sat_sub(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [WIDTH:0] d;
        d = (WIDTH+1)'(a) - (WIDTH+1)'(b);
        if (d[WIDTH] != d[WIDTH-1]) begin
            return d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return d[WIDTH-1:0];
    endfunction

    // State register plus registered state-decode outputs.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from the same pre-edge values.
        if (rst_in) begin
            state          <= ST_IDLE;
            busy_out       <= 1'b0;
            calibrated_out <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            state          <= next_state;
            busy_out       <= busy_d;
            calibrated_out <= cal_d;
            done_out       <= done_d;
        end
    end

    // Next-state logic; a start request overrides everything else.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch
        // is inferred.
        next_state = state;
        if (cal_start_in) begin
            next_state = START_STATE;
        end else begin
            unique case (state)
                ST_IDLE:   next_state = ST_IDLE;
                ST_SETTLE: if (sample_valid_in && settle_last) next_state = ST_ACCUM;
                ST_ACCUM:  if (sample_valid_in && accum_last)  next_state = ST_LATCH;
                ST_LATCH:  next_state = ST_CAL;
                ST_CAL:    next_state = ST_CAL;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state, registered alongside the state.
    always_comb begin
        busy_d = next_state inside {ST_SETTLE, ST_ACCUM, ST_LATCH};
        cal_d  = (next_state == ST_CAL);
        done_d = (state == ST_LATCH) && (next_state == ST_CAL);
    end

    // Sample counter and per-axis accumulators; cleared on every start.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt   <= '0;
            acc_x <= '0;
            acc_y <= '0;
            acc_z <= '0;
        end else if (cal_start_in) begin
            cnt   <= '0;
            acc_x <= '0;
            acc_y <= '0;
            acc_z <= '0;
        end else if (sample_valid_in) begin
            if (state == ST_SETTLE) begin
                // Wrap to zero so ACCUM starts counting from a clean counter.
                cnt <= settle_last ? '0 : cnt + CNT_W'(1);
            end else if (state == ST_ACCUM) begin
                cnt   <= cnt + CNT_W'(1);
                acc_x <= acc_x + ACC_W'(gx_in);
                acc_y <= acc_y + ACC_W'(gy_in);
                acc_z <= acc_z + ACC_W'(gz_in);
            end
        end
    end

    // Bias registers: floor average taken in LATCH unless a restart arrives.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bias_x_out <= '0;
            bias_y_out <= '0;
            bias_z_out <= '0;
        end else if (state == ST_LATCH && !cal_start_in) begin
            bias_x_out <= WIDTH'(acc_x >>> LOG_SAMPLES);
            bias_y_out <= WIDTH'(acc_y >>> LOG_SAMPLES);
            bias_z_out <= WIDTH'(acc_z >>> LOG_SAMPLES);
        end
    end

    // Corrected output stage; data holds between strobes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            gx_out    <= '0;
            gy_out    <= '0;
            gz_out    <= '0;
        end else begin
            valid_out <= sample_valid_in;
            if (sample_valid_in) begin
                gx_out <= sat_sub(gx_in, bias_x_out);
                gy_out <= sat_sub(gy_in, bias_y_out);
                gz_out <= sat_sub(gz_in, bias_z_out);
            end
        end
    end

endmodule

// File: tb/tb_gyro_bias_calibrator.sv
// tb_gyro_bias_calibrator: directed plus random stimulus, expected samples
// queued by a behavioural model and checked by an independent monitor.
module tb_gyro_bias_calibrator;

    localparam int W = 16;
    localparam int L = 4;
    localparam int S = 2;
    localparam int N = 1 << L;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b1;
    logic                cal_start_in = 1'b0;
    logic                sample_valid_in = 1'b0;
    logic signed [W-1:0] gx_in = '0;
    logic signed [W-1:0] gy_in = '0;
    logic signed [W-1:0] gz_in = '0;
    logic signed [W-1:0] gx_out;
    logic signed [W-1:0] gy_out;
    logic signed [W-1:0] gz_out;
    logic                valid_out;
    logic signed [W-1:0] bias_x_out;
    logic signed [W-1:0] bias_y_out;
    logic signed [W-1:0] bias_z_out;
    logic                busy_out;
    logic                calibrated_out;
    logic                done_out;

    always #5 clk_in = ~clk_in;

    gyro_bias_calibrator #(
        .WIDTH(W),
        .LOG_SAMPLES(L),
        .SETTLE_SAMPLES(S)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .cal_start_in(cal_start_in),
        .sample_valid_in(sample_valid_in),
        .gx_in(gx_in),
        .gy_in(gy_in),
        .gz_in(gz_in),
        .gx_out(gx_out),
        .gy_out(gy_out),
        .gz_out(gz_out),
        .valid_out(valid_out),
        .bias_x_out(bias_x_out),
        .bias_y_out(bias_y_out),
        .bias_z_out(bias_z_out),
        .busy_out(busy_out),
        .calibrated_out(calibrated_out),
        .done_out(done_out)
    );

    typedef struct {
        int x;
        int y;
        int z;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_count = 0;
    bit   mon_en = 0;

    // Reference model state.
    int   bias[3];
    int   pend_bias[3];
    int   pend;
    bit   cal_active;
    bit   cal_flag;
    int   discard;
    int   samp_x[$];
    int   samp_y[$];
    int   samp_z[$];

    // Expectations for the current cycle, read by the monitor.
    bit   e_busy;
    bit   e_cal;
    bit   e_done;
    int   e_bias[3];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Mean rounded toward minus infinity.
    function automatic int floor_avg(input int q[$]);
        int sum = 0;
        int r;
        foreach (q[i]) sum += q[i];
        r = sum / q.size();
        if ((sum % q.size()) != 0 && sum < 0) r -= 1;
        return r;
    endfunction

    task automatic model_clear();
        bias       = '{0, 0, 0};
        pend_bias  = '{0, 0, 0};
        pend       = 0;
        cal_active = 0;
        cal_flag   = 0;
        discard    = 0;
        samp_x.delete();
        samp_y.delete();
        samp_z.delete();
    endtask

    // One clock cycle of stimulus; updates the model and queues expectations.
    task automatic cycle(input bit r, input bit st, input bit v,
                         input int x, input int y, input int z);
        e_done = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bias     = pend_bias;
                cal_flag = 1;
                e_done   = 1;
            end
        end
        e_busy = cal_active || (pend == 1);
        e_cal  = cal_flag;
        e_bias = bias;

        rst_in          = r;
        cal_start_in    = st;
        sample_valid_in = v;
        gx_in           = 16'(x);
        gy_in           = 16'(y);
        gz_in           = 16'(z);

        if (r) begin
            model_clear();
        end else begin
            if (v) exp_q.push_back('{sat(x - bias[0]), sat(y - bias[1]), sat(z - bias[2]), cyc + 1});
            if (st) begin
                cal_active = 1;
                discard    = S;
                pend       = 0;
                cal_flag   = 0;
                samp_x.delete();
                samp_y.delete();
                samp_z.delete();
            end else if (v && cal_active) begin
                if (discard > 0) begin
                    discard--;
                end else begin
                    samp_x.push_back(x);
                    samp_y.push_back(y);
                    samp_z.push_back(z);
                    if (samp_x.size() == N) begin
                        cal_active = 0;
                        pend       = 2;
                        pend_bias  = '{floor_avg(samp_x), floor_avg(samp_y), floor_avg(samp_z)};
                    end
                end
            end
        end
        @(posedge clk_in);
        #1;
        cyc++;
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    // Full calibration with constant samples after the settle window.
    task automatic calibrate(input int x, input int y, input int z);
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < S; i++) cycle(0, 0, 1, 9999, 9999, 9999);
        for (int i = 0; i < N; i++) cycle(0, 0, 1, x, y, z);
        idle(2);
    endtask

    // Monitor: pops expected samples when the DUT strobes, checks status.
    exp_t t;
    always @(negedge clk_in) begin
        if (mon_en) begin
            if (done_out) done_count++;
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    t = exp_q.pop_front();
                    check("out_cycle", cyc, t.due);
                    check("gx_out", int'(gx_out), t.x);
                    check("gy_out", int'(gy_out), t.y);
                    check("gz_out", int'(gz_out), t.z);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                check("missing_valid", 0, 1);
                void'(exp_q.pop_front());
            end
            check("busy_out", int'(busy_out), int'(e_busy));
            check("calibrated_out", int'(calibrated_out), int'(e_cal));
            check("done_out", int'(done_out), int'(e_done));
            check("bias_x_out", int'(bias_x_out), e_bias[0]);
            check("bias_y_out", int'(bias_y_out), e_bias[1]);
            check("bias_z_out", int'(bias_z_out), e_bias[2]);
        end
    end

    initial begin
        bit r;
        bit st;
        bit v;
        int x;
        int y;
        int z;
        int dc;

        model_clear();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // Pass-through after reset.
        cycle(0, 0, 1, 1234, -5, 0);
        check("pass_valid", int'(valid_out), 1);
        check("pass_gx", int'(gx_out), 1234);
        check("pass_gy", int'(gy_out), -5);
        check("pass_gz", int'(gz_out), 0);
        check("pass_cal", int'(calibrated_out), 0);
        idle(1);

        // Constant calibration with exact done timing.
        dc = done_count;
        cycle(0, 1, 0, 0, 0, 0);
        check("busy_after_start", int'(busy_out), 1);
        for (int i = 0; i < S; i++) cycle(0, 0, 1, 9999, 9999, 9999);
        for (int i = 0; i < N; i++) cycle(0, 0, 1, 100, -37, 0);
        check("latch_done_low", int'(done_out), 0);
        idle(1);
        check("const_done", int'(done_out), 1);
        check("const_cal", int'(calibrated_out), 1);
        check("const_bias_x", int'(bias_x_out), 100);
        check("const_bias_y", int'(bias_y_out), -37);
        check("const_bias_z", int'(bias_z_out), 0);
        idle(1);
        check("done_one_pulse", int'(done_out), 0);
        check("done_count", done_count - dc, 1);
        cycle(0, 0, 1, 150, 0, 0);
        check("corrected_gx", int'(gx_out), 50);

        // Floor rounding.
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < S; i++) cycle(0, 0, 1, 5, 5, 5);
        for (int i = 0; i < N; i++) cycle(0, 0, 1, 1, 0, (i % 2 == 0) ? -1 : 0);
        idle(2);
        check("floor_bias_x", int'(bias_x_out), 1);
        check("floor_bias_z", int'(bias_z_out), -1);

        // Saturation in both directions.
        calibrate(-100, 0, 0);
        cycle(0, 0, 1, 32700, 0, 0);
        check("sat_pos", int'(gx_out), 32767);
        calibrate(100, 0, 0);
        cycle(0, 0, 1, -32700, 0, 0);
        check("sat_neg", int'(gx_out), -32768);

        // Restart mid-ACCUM, simultaneous with a valid sample.
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < S; i++) cycle(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 200, 0, 0);
        cycle(0, 1, 1, 300, 0, 0);
        check("restart_sample", int'(gx_out), 200);
        for (int i = 0; i < S; i++) cycle(0, 0, 1, 7000, 0, 0);
        for (int i = 0; i < N; i++) cycle(0, 0, 1, 40, 0, 0);
        idle(2);
        check("restart_bias_x", int'(bias_x_out), 40);

        // Randomised traffic with occasional starts and resets.
        for (int i = 0; i < 700; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            st = !r && ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            x  = int'($urandom_range(0, 65535)) - 32768;
            y  = int'($urandom_range(0, 2000)) - 1000;
            z  = int'($urandom_range(0, 65535)) - 32768;
            cycle(r, st, v, x, y, z);
        end
        idle(3);

        // Reset mid-ACCUM discards everything.
        calibrate(321, -321, 55);
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < S + 5; i++) cycle(0, 0, 1, 10, 10, 10);
        cycle(1, 0, 0, 0, 0, 0);
        check("rst_bias_x", int'(bias_x_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_valid", int'(valid_out), 0);
        check("rst_gx", int'(gx_out), 0);
        cycle(0, 0, 1, 777, -777, 1);
        check("post_rst_gx", int'(gx_out), 777);
        check("post_rst_gy", int'(gy_out), -777);
        idle(3);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
